// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants, scan state type and anode helper functions
//               for the multiplexed 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int         NUM_DIGITS      = 3;
  localparam int         SEG_W           = 7;
  localparam logic [6:0] SEG_OFF_DEFAULT = 7'b1111111;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Anode word with every digit dark, for either anode polarity.
  function automatic logic [NUM_DIGITS-1:0] an_all_off(input logic active_low);
    return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  endfunction

  // Anode word enabling only digit idx, for either anode polarity.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx,
                                                      input logic       active_low);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = '0;
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      default: onehot = 3'b100;
    endcase
    return active_low ? ~onehot : onehot;
  endfunction

  // Digit index sequence 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_digit(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux_if
// Description : Pattern/control inputs and display-drive outputs of the
//               multiplexed 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_mux_if;
  import seg_pkg::*;

  logic                  en;
  logic [NUM_DIGITS-1:0] dig_mask;
  logic [SEG_W-1:0]      seg0_in;
  logic [SEG_W-1:0]      seg1_in;
  logic [SEG_W-1:0]      seg2_in;
  logic [SEG_W-1:0]      seg_out;
  logic [NUM_DIGITS-1:0] an_out;
  logic [1:0]            digit_idx;
  logic                  frame_tick;

  // Upstream side: supplies patterns and control, observes the display drive.
  modport master (
    output en, dig_mask, seg0_in, seg1_in, seg2_in,
    input  seg_out, an_out, digit_idx, frame_tick
  );

  // Scanner side.
  modport slave (
    input  en, dig_mask, seg0_in, seg1_in, seg2_in,
    output seg_out, an_out, digit_idx, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_slot_timer
// Description : Slot counter and digit index for the scanner. Emits the
//               strobes marking entry into SHOW, slot wrap and frame wrap.
//               Strobes are decoded from registered state and are valid in
//               the cycle before the edge they describe.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,  // cycles per slot, >= 2
  parameter int BLANK_CYCLES = 500     // blank cycles per slot, < REFRESH_DIV
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       en_i,
  output logic            show_start_o,
  output logic            slot_wrap_o,
  output logic            frame_wrap_o,
  output logic [1:0]      digit_idx_o
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       digit_idx_q;
  logic             w_wrap;

  assign w_wrap = en_i && (cnt_q == CNT_LAST);

  // With no blank phase there is no BLANK->SHOW edge inside the slot.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
      assign show_start_o = en_i && (cnt_q == CNT_BLANK_LAST);
    end else begin : g_no_blank
      assign show_start_o = 1'b0;
    end
  endgenerate

  assign slot_wrap_o  = w_wrap;
  assign frame_wrap_o = w_wrap && (digit_idx_q == 2'd2);
  assign digit_idx_o  = digit_idx_q;

  // Slot counter and digit index; a low enable parks both at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      digit_idx_q <= 2'd0;
    end else if (!en_i) begin
      cnt_q       <= '0;
      digit_idx_q <= 2'd0;
    end else if (w_wrap) begin
      cnt_q       <= '0;
      digit_idx_q <= next_digit(digit_idx_q);
    end else begin
      cnt_q       <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexes three 7-segment patterns onto a shared
//               segment bus with per-slot blanking, per-digit masking and a
//               frame strobe. All outputs are registered; the output
//               registers double as the pattern/mask latch for the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int               REFRESH_DIV   = 50000,
  parameter int               BLANK_CYCLES  = 500,
  parameter logic             AN_ACTIVE_LOW = 1'b1,
  parameter logic [SEG_W-1:0] SEG_OFF       = SEG_OFF_DEFAULT
) (
  input wire logic      clk,
  input wire logic      rst_n,
  seg_scan_mux_if.slave bus
);

  localparam logic [NUM_DIGITS-1:0] AN_OFF   = an_all_off(AN_ACTIVE_LOW);
  localparam logic                  NO_BLANK = (BLANK_CYCLES == 0);

  logic                  w_show_start;
  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic [1:0]            w_digit_idx;

  scan_state_e           state_q;
  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_q;

  logic [1:0]            w_load_idx;
  logic [SEG_W-1:0]      w_load_pat;
  logic                  w_load_en;
  logic [SEG_W-1:0]      w_load_seg;
  logic [NUM_DIGITS-1:0] w_load_an;

  seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (bus.en),
    .show_start_o (w_show_start),
    .slot_wrap_o  (w_slot_wrap),
    .frame_wrap_o (w_frame_wrap),
    .digit_idx_o  (w_digit_idx)
  );

  // A load from BLANK shows the current digit; a load at a wrap while
  // already in SHOW (no blank phase) shows the digit the timer moves to.
  always_comb begin
    w_load_idx = (state_q == ST_SHOW) ? next_digit(w_digit_idx) : w_digit_idx;
    case (w_load_idx)
      2'd0:    w_load_pat = bus.seg0_in;
      2'd1:    w_load_pat = bus.seg1_in;
      default: w_load_pat = bus.seg2_in;
    endcase
    w_load_en  = bus.dig_mask[w_load_idx];
    w_load_seg = w_load_en ? w_load_pat : SEG_OFF;
    w_load_an  = w_load_en ? an_select(w_load_idx, AN_ACTIVE_LOW) : AN_OFF;
  end

  // Scan FSM with registered segment/anode/frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else if (!bus.en) begin
      state_q <= ST_BLANK;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= w_frame_wrap;
      case (state_q)
        ST_BLANK: begin
          // Without a blank phase, BLANK is only the post-reset/enable start.
          if (NO_BLANK || w_show_start) begin
            state_q <= ST_SHOW;
            seg_q   <= w_load_seg;
            an_q    <= w_load_an;
          end
        end
        ST_SHOW: begin
          if (w_slot_wrap) begin
            if (NO_BLANK) begin
              seg_q <= w_load_seg;
              an_q  <= w_load_an;
            end else begin
              state_q <= ST_BLANK;
              seg_q   <= SEG_OFF;
              an_q    <= AN_OFF;
            end
          end
        end
        default: begin
          state_q <= ST_BLANK;
          seg_q   <= SEG_OFF;
          an_q    <= AN_OFF;
        end
      endcase
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.digit_idx  = w_digit_idx;
  assign bus.frame_tick = frame_q;

endmodule
`default_nettype wire
